// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and an opcode from a UART
// receiver, computes one ALU result and hands it to a UART transmitter.
// Bytes that arrive while a result is being computed or sent are dropped and
// recorded in a sticky overrun flag.
module uart_alu_ctrl #(
  parameter int NBIT_DATA = 8,
  parameter int NBIT_OP   = 6
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 rx_done_tick,
  input  logic [NBIT_DATA-1:0] rx_data,
  input  logic                 tx_done_tick,
  output logic                 tx_start,
  output logic [NBIT_DATA-1:0] tx_data,
  output logic [NBIT_DATA-1:0] result,
  output logic                 op_err,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_e;

  // Opcode encodings; only the low NBIT_OP bits of the received byte matter.
  localparam logic [NBIT_OP-1:0] OP_ADD = NBIT_OP'('h20);
  localparam logic [NBIT_OP-1:0] OP_SUB = NBIT_OP'('h22);
  localparam logic [NBIT_OP-1:0] OP_AND = NBIT_OP'('h24);
  localparam logic [NBIT_OP-1:0] OP_OR  = NBIT_OP'('h25);
  localparam logic [NBIT_OP-1:0] OP_XOR = NBIT_OP'('h26);
  localparam logic [NBIT_OP-1:0] OP_NOR = NBIT_OP'('h27);
  localparam logic [NBIT_OP-1:0] OP_SRA = NBIT_OP'('h03);
  localparam logic [NBIT_OP-1:0] OP_SRL = NBIT_OP'('h02);

  state_e               state_q, state_d;
  logic [NBIT_DATA-1:0] a_q, a_d;
  logic [NBIT_DATA-1:0] b_q, b_d;
  logic [NBIT_OP-1:0]   op_q, op_d;
  logic [NBIT_DATA-1:0] result_q, result_d;
  logic [NBIT_DATA-1:0] tx_data_q, tx_data_d;
  logic                 op_err_q, op_err_d;
  logic                 overrun_q, overrun_d;

  logic [NBIT_DATA-1:0] alu_value;
  logic                 alu_valid;
  logic                 shift_big;

  // A shift amount of NBIT_DATA or more pushes every original bit out.
  assign shift_big = (32'(b_q) >= 32'(NBIT_DATA));

  // ALU: pure function of the latched operands and opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    alu_value = '0;
    alu_valid = 1'b1;
    case (op_q)
      OP_ADD:  alu_value = a_q + b_q;
      OP_SUB:  alu_value = a_q - b_q;
      OP_AND:  alu_value = a_q & b_q;
      OP_OR:   alu_value = a_q | b_q;
      OP_XOR:  alu_value = a_q ^ b_q;
      OP_NOR:  alu_value = ~(a_q | b_q);
      OP_SRL:  alu_value = shift_big ? '0 : (a_q >> b_q);
      OP_SRA:  alu_value = shift_big ? {NBIT_DATA{a_q[NBIT_DATA-1]}}
                                     : NBIT_DATA'($signed(a_q) >>> b_q);
      default: alu_valid = 1'b0;
    endcase
  end

  // Next-state and datapath-register update for the byte-sequencing FSM.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    tx_data_d = tx_data_q;
    op_err_d  = op_err_q;
    overrun_d = overrun_q;
    case (state_q)
      WAIT_A: if (rx_done_tick) begin
        a_d     = rx_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (rx_done_tick) begin
        b_d     = rx_data;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (rx_done_tick) begin
        op_d    = rx_data[NBIT_OP-1:0];
        state_d = EXEC;
      end
      EXEC: begin
        result_d  = alu_valid ? alu_value : '0;
        tx_data_d = alu_valid ? alu_value : '0;
        op_err_d  = ~alu_valid;
        state_d   = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
    // A byte arriving while busy is lost; remember that until reset.
    if (rx_done_tick && (state_q inside {EXEC, SEND, WAIT_TX})) overrun_d = 1'b1;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      tx_data_q <= '0;
      op_err_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      tx_data_q <= tx_data_d;
      op_err_q  <= op_err_d;
      overrun_q <= overrun_d;
    end
  end

  // SEND lasts exactly one cycle, so decoding it gives a single-cycle pulse.
  assign tx_start = (state_q == SEND);
  assign tx_data  = tx_data_q;
  assign result   = result_q;
  assign op_err   = op_err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed testbench for uart_alu_ctrl: byte triples with hand-computed
// results, opcode errors, overrun handling and reset in mid-sequence.
module tb_uart_alu_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] result;
  logic       op_err;
  logic       overrun;

  int   n_pass = 0;
  int   n_total = 0;
  logic early_start;

  uart_alu_ctrl #(.NBIT_DATA(8), .NBIT_OP(6)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .result       (result),
    .op_err       (op_err),
    .overrun      (overrun)
  );

  always #5 CLK = ~CLK;

  // Drive one received byte for one cycle; any tx_start seen meanwhile is noted.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    early_start = early_start | tx_start;
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge CLK);
    early_start = early_start | tx_start;
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge CLK);
    tx_done_tick = 1'b1;
    @(negedge CLK);
    tx_done_tick = 1'b0;
  endtask

  // Hold reset low across a few edges, checking outputs clear asynchronously.
  task automatic apply_reset(input string name);
    @(negedge CLK);
    reset = 1'b0;
    #2;
    n_total++;
    if ({tx_start, tx_data, result, op_err, overrun} !== 19'h0) begin
      $display("FAIL %s async reset outputs: got %h required 0", name,
               {tx_start, tx_data, result, op_err, overrun});
    end else n_pass++;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  // Send A, B, opcode and check the single tx_start pulse and its payload.
  task automatic run_triple(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp,
                            input logic exp_err, input bit finish,
                            input bit stray_tx, input string name);
    early_start = 1'b0;
    send_byte(a);
    if (stray_tx) pulse_tx_done();
    send_byte(b);
    if (stray_tx) pulse_tx_done();
    send_byte(op);
    // One cycle after the opcode tick: FSM is in EXEC, no request yet.
    n_total++;
    if (early_start !== 1'b0) begin
      $display("FAIL %s early tx_start: got %b required 0", name, early_start);
    end else n_pass++;
    @(negedge CLK);
    n_total++;
    if (tx_start !== 1'b1) begin
      $display("FAIL %s tx_start at latency 2: got %b required 1", name, tx_start);
    end else n_pass++;
    n_total++;
    if (tx_data !== exp) begin
      $display("FAIL %s tx_data: got %h required %h", name, tx_data, exp);
    end else n_pass++;
    n_total++;
    if (result !== exp) begin
      $display("FAIL %s result: got %h required %h", name, result, exp);
    end else n_pass++;
    n_total++;
    if (op_err !== exp_err) begin
      $display("FAIL %s op_err: got %b required %b", name, op_err, exp_err);
    end else n_pass++;
    @(negedge CLK);
    n_total++;
    if ({tx_start, tx_data} !== {1'b0, exp}) begin
      $display("FAIL %s single pulse / held data: got %h required %h", name,
               {tx_start, tx_data}, {1'b0, exp});
    end else n_pass++;
    if (finish) begin
      tx_done_tick = 1'b1;
      @(negedge CLK);
      tx_done_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({tx_start, tx_data, result, op_err, overrun} !== 19'h0) begin
      $display("FAIL reset state: got %h required 0",
               {tx_start, tx_data, result, op_err, overrun});
    end else n_pass++;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_arith();
    run_triple(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1, 0, "add");
    run_triple(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, 1, 0, "sub_wrap");
    run_triple(8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, 1, 0, "sra_big");
    run_triple(8'h80, 8'h01, 8'h02, 8'h40, 1'b0, 1, 0, "srl_1");
    run_triple(8'hFF, 8'h08, 8'h02, 8'h00, 1'b0, 1, 0, "srl_big");
    run_triple(8'h70, 8'h02, 8'h03, 8'h1C, 1'b0, 1, 0, "sra_pos");
    run_triple(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0, 1, 1, "nor_stray_tx_done");
    run_triple(8'h21, 8'h01, 8'hE0, 8'h22, 1'b0, 1, 0, "add_upper_op_bits");
  endtask

  task automatic test_op_err();
    run_triple(8'h0F, 8'hF0, 8'h3F, 8'h00, 1'b1, 1, 0, "invalid_op");
    run_triple(8'hAA, 8'h0F, 8'h24, 8'h0A, 1'b0, 1, 0, "and_clears_err");
  endtask

  task automatic test_overrun();
    run_triple(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 0, 0, "ovr_first");
    n_total++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun before extra byte: got %b required 0", overrun);
    end else n_pass++;
    send_byte(8'h99);
    n_total++;
    if ({overrun, tx_start, tx_data} !== {1'b1, 1'b0, 8'h08}) begin
      $display("FAIL overrun in WAIT_TX: got %h required %h",
               {overrun, tx_start, tx_data}, {1'b1, 1'b0, 8'h08});
    end else n_pass++;
    pulse_tx_done();
    run_triple(8'h10, 8'h33, 8'h26, 8'h23, 1'b0, 1, 0, "xor_after_overrun");
    n_total++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun sticky: got %b required 1", overrun);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    early_start = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    apply_reset("mid_b");
    run_triple(8'h01, 8'h02, 8'h25, 8'h03, 1'b0, 1, 0, "or_after_reset");
    // Reset while waiting for the transmitter, then only one new byte.
    run_triple(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 0, 0, "pre_reset_tx");
    apply_reset("wait_tx");
    early_start = 1'b0;
    send_byte(8'h01);
    repeat (6) begin
      @(negedge CLK);
      early_start = early_start | tx_start;
    end
    n_total++;
    if (early_start !== 1'b0) begin
      $display("FAIL no tx_start after reset in WAIT_TX: got %b required 0", early_start);
    end else n_pass++;
    apply_reset("cleanup");
  endtask

  task automatic test_simultaneous();
    run_triple(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0, 0, 0, "nor_pre_sim");
    rx_data      = 8'h77;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    @(negedge CLK);
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    n_total++;
    if (overrun !== 1'b1) begin
      $display("FAIL simultaneous rx/tx overrun: got %b required 1", overrun);
    end else n_pass++;
    run_triple(8'h21, 8'h01, 8'hE0, 8'h22, 1'b0, 1, 0, "after_sim_drop");
  endtask

  initial begin
    test_reset();
    test_arith();
    test_op_err();
    test_overrun();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
